// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and FSM encoding for the memory burst controller
package mem_pkg;
    localparam int WIDTH      = 8;
    localparam int DEPTH      = 32;
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    localparam logic MEM_WR = 1'b1;
    localparam logic MEM_RD = 1'b0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WGET = 3'd1,
        WREQ = 3'd2,
        RREQ = 3'd3,
        DONE = 3'd4
    } burst_state_t;
endpackage

// File: rtl/mem_addr_gen.sv
// rtl/mem_addr_gen.sv - burst address walker (modulo DEPTH) and remaining-word counter
module mem_addr_gen #(
    parameter int DEPTH = mem_pkg::DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_word
);
    import mem_pkg::*;

    localparam logic [ADDR_WIDTH:0]   MAX_LEN   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH-1);

    logic [ADDR_WIDTH:0] remaining;

    // Oversized bursts are clamped so a burst never revisits an address
    always_ff @(posedge clk) begin
        if (!res) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= start_addr;
            remaining <= (len > MAX_LEN) ? MAX_LEN : len;
        end else if (advance) begin
            addr      <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    assign last_word = (remaining == (ADDR_WIDTH+1)'(1));
endmodule

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst sequencer turning one command into single-word memory transfers
module mem_burst_ctrl #(
    parameter int WIDTH = mem_pkg::WIDTH,
    parameter int DEPTH = mem_pkg::DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [WIDTH-1:0]      wd_data,
    output logic                  rd_valid,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  done,
    output logic                  busy,
    output logic                  m_valid,
    output logic                  m_wr_rd,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0]      m_wdata,
    input  logic [WIDTH-1:0]      m_rdata,
    input  logic                  m_ready
);
    import mem_pkg::*;

    burst_state_t          state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  last_word;
    logic                  load;
    logic                  advance;

    assign cmd_ready = (state == IDLE);
    assign wd_ready  = (state == WGET);
    assign load      = cmd_ready && cmd_valid;
    assign advance   = m_valid && m_ready && ((state == WREQ) || (state == RREQ));

    mem_addr_gen #(.DEPTH(DEPTH)) u_addr_gen (
        .clk        (clk),
        .res        (res),
        .load       (load),
        .start_addr (cmd_addr),
        .len        (cmd_len),
        .advance    (advance),
        .addr       (cur_addr),
        .last_word  (last_word)
    );

    always_ff @(posedge clk) begin
        if (!res) begin
            state    <= IDLE;
            m_valid  <= 1'b0;
            m_wr_rd  <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    busy <= 1'b1;
                    if (cmd_len == '0)          state <= DONE;
                    else if (cmd_wr == MEM_WR)  state <= WGET;
                    else                        state <= RREQ;
                end
                WGET: if (wd_valid) begin
                    m_valid <= 1'b1;
                    m_wr_rd <= MEM_WR;
                    m_addr  <= cur_addr;
                    m_wdata <= wd_data;
                    state   <= WREQ;
                end
                WREQ: if (m_ready) begin
                    m_valid <= 1'b0;
                    state   <= last_word ? DONE : WGET;
                end
                // Reads alternate issue and accept cycles, leaving a gap between words
                RREQ: if (!m_valid) begin
                    m_valid <= 1'b1;
                    m_wr_rd <= MEM_RD;
                    m_addr  <= cur_addr;
                end else if (m_ready) begin
                    m_valid  <= 1'b0;
                    rd_valid <= 1'b1;
                    rd_data  <= m_rdata;
                    if (last_word) state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - randomized bench for mem_burst_ctrl against a queue-based burst model
module tb_mem_burst_ctrl;
    localparam int W  = 8;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          res;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          wd_valid, wd_ready;
    logic [W-1:0]  wd_data;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic          done, busy;
    logic          m_valid, m_wr_rd;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_wdata, m_rdata;
    logic          m_ready;

    mem_burst_ctrl dut (
        .clk(clk), .res(res),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy),
        .m_valid(m_valid), .m_wr_rd(m_wr_rd), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [W-1:0] dev_mem [D];
    logic [W-1:0] ref_mem [D];
    logic [W-1:0] wd_q [$];
    int xa [$];
    int xd [$];
    int xw [$];
    int rd_log [$];
    int wd_idx, wd_used, done_cnt, done_cyc, acc_cyc, stall_left;
    int stall_after = 1000;
    bit in_req, exp_rd, exp_hold, exp_gap, long_stall, gappy;
    int exp_rd_data, hold_addr, hold_wdata, hold_wr;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe the result of the last edge, then drive memory and write-data for the next
    task automatic step();
        bit skip;
        @(negedge clk);
        cyc++;
        skip = !res;
        if (!skip) begin
            if (exp_rd) begin
                check("rd_valid", int'(rd_valid), 1);
                check("rd_data", int'(rd_data), exp_rd_data);
                rd_log.push_back(int'(rd_data));
            end else begin
                check("rd_valid_quiet", int'(rd_valid), 0);
            end
            if (exp_hold) begin
                check("m_valid_hold", int'(m_valid), 1);
                check("m_addr_hold", int'(m_addr), hold_addr);
                check("m_wdata_hold", int'(m_wdata), hold_wdata);
                check("m_wr_rd_hold", int'(m_wr_rd), hold_wr);
            end
            if (exp_gap) check("m_valid_gap", int'(m_valid), 0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        exp_rd = 0; exp_hold = 0; exp_gap = 0;

        if (!m_valid) in_req = 0;
        else if (!in_req) begin
            in_req = 1;
            stall_left = long_stall ? 3 : int'($urandom_range(0, 2));
        end
        if (m_valid) m_ready = (stall_left == 0) && (xa.size() < stall_after);
        else         m_ready = 1'($urandom);
        m_rdata = 8'($urandom);
        if (m_valid && !m_ready) begin
            if (stall_left > 0) stall_left--;
            exp_hold   = 1;
            hold_addr  = int'(m_addr);
            hold_wdata = int'(m_wdata);
            hold_wr    = int'(m_wr_rd);
        end
        if (m_valid && m_ready) begin
            xa.push_back(int'(m_addr));
            xw.push_back(int'(m_wr_rd));
            if (m_wr_rd) begin
                dev_mem[m_addr] = m_wdata;
                xd.push_back(int'(m_wdata));
            end else begin
                m_rdata     = dev_mem[m_addr];
                exp_rd      = 1;
                exp_rd_data = int'(dev_mem[m_addr]);
            end
            in_req  = 0;
            exp_gap = 1;
        end

        if (wd_idx < wd_q.size()) begin
            wd_valid = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
            wd_data  = wd_q[wd_idx];
        end else begin
            wd_valid = 1'($urandom);
            wd_data  = 8'($urandom);
        end
        if (wd_valid && wd_ready) begin
            wd_used++;
            if (wd_idx < wd_q.size()) wd_idx++;
        end
    endtask

    task automatic issue(input bit wr, input int addr, input int len);
        int t;
        wd_idx = 0; wd_used = 0; done_cnt = 0;
        xa.delete(); xd.delete(); xw.delete(); rd_log.delete();
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = AW'(addr);
        cmd_len   = (AW+1)'(len);
        t = 0;
        while (!cmd_ready && t < 50) begin
            step();
            t++;
        end
        check("cmd_ready_idle", int'(cmd_ready), 1);
        acc_cyc = cyc;
        step();
        cmd_valid = 1'b0;
        cmd_wr    = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_len   = (AW+1)'($urandom);
        check("busy_on_accept", int'(busy), 1);
        check("cmd_ready_busy", int'(cmd_ready), 0);
    endtask

    task automatic run_burst(input bit wr, input int addr, input int len);
        int n, t;
        n = (len > D) ? D : len;
        if (!wr) wd_q.delete();
        else while (wd_q.size() < n) wd_q.push_back(8'($urandom));
        issue(wr, addr, len);
        t = 0;
        while (done_cnt == 0 && t < 1500) begin
            step();
            t++;
            if (done_cnt == 0) check("cmd_ready_busy", int'(cmd_ready), 0);
        end
        check("done_seen", done_cnt, 1);
        check("busy_at_done", int'(busy), 0);
        if (len == 0) check("len0_done_latency", done_cyc - acc_cyc, 2);
        step();
        check("done_one_cycle", int'(done), 0);
        check("xfer_count", xa.size(), n);
        for (int i = 0; i < n && i < xa.size(); i++) begin
            check("xfer_addr", xa[i], (addr + i) % D);
            check("xfer_dir", xw[i], int'(wr));
        end
        if (wr) begin
            check("wd_consumed", wd_used, n);
            for (int i = 0; i < n && i < xd.size(); i++)
                check("xfer_wdata", xd[i], int'(wd_q[i]));
            for (int i = 0; i < n; i++)
                ref_mem[(addr + i) % D] = wd_q[i];
        end else begin
            check("wd_consumed", wd_used, 0);
            check("rd_count", rd_log.size(), n);
            for (int i = 0; i < n && i < rd_log.size(); i++)
                check("rd_word", rd_log[i], int'(ref_mem[(addr + i) % D]));
        end
        wd_q.delete();
    endtask

    initial begin
        int a, t;
        res = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; m_rdata = '0; m_ready = 1'b0;
        long_stall = 0; gappy = 0; in_req = 0; stall_left = 0;
        exp_rd = 0; exp_hold = 0; exp_gap = 0;
        for (int i = 0; i < D; i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end

        step(); step();
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_wd_ready", int'(wd_ready), 0);
        res = 1'b1;
        step();

        wd_q.push_back(8'hA5);
        run_burst(1, 15, 1);
        run_burst(0, 15, 1);

        for (int i = 0; i < 5; i++) wd_q.push_back(8'(8'h11 + i));
        run_burst(1, 20, 5);
        run_burst(0, 20, 5);

        for (int i = 1; i <= 4; i++) wd_q.push_back(8'(i));
        run_burst(1, 30, 4);
        run_burst(0, 0, 2);

        long_stall = 1; gappy = 1;
        run_burst(1, 5, 6);
        run_burst(0, 5, 6);
        long_stall = 0; gappy = 0;

        run_burst(1, 9, 0);
        run_burst(0, 9, 0);
        run_burst(1, 17, 32);
        run_burst(0, 0, 32);
        run_burst(1, 7, 40);
        run_burst(0, 7, 40);

        for (int k = 0; k < 20; k++) begin
            long_stall = ($urandom_range(0, 3) == 0);
            gappy      = 1'($urandom);
            run_burst(1'($urandom), int'($urandom_range(0, D-1)), int'($urandom_range(0, 40)));
        end
        long_stall = 0; gappy = 1;

        a = int'($urandom_range(0, D-1));
        for (int i = 0; i < 8; i++) wd_q.push_back(8'($urandom));
        stall_after = 2;
        issue(1, a, 8);
        t = 0;
        while (!(m_valid && xa.size() == 2) && t < 300) begin
            step();
            t++;
        end
        check("reset_reached_word3", xa.size(), 2);
        res = 1'b0;
        step();
        check("mid_rst_m_valid", int'(m_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_rd_valid", int'(rd_valid), 0);
        check("mid_rst_cmd_ready", int'(cmd_ready), 1);
        check("mid_rst_wd_ready", int'(wd_ready), 0);
        check("mid_rst_m_addr", int'(m_addr), 0);
        check("mid_rst_m_wdata", int'(m_wdata), 0);
        check("mid_rst_m_wr_rd", int'(m_wr_rd), 0);
        check("mid_rst_rd_data", int'(rd_data), 0);
        res = 1'b1;
        stall_after = 1000;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) step();
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_xfers", xa.size(), 2);
        for (int i = 0; i < 2; i++) ref_mem[(a + i) % D] = wd_q[i];
        wd_q.delete();
        run_burst(0, a, 2);
        run_burst(1, a, 3);
        run_burst(0, a, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Burst master that sits directly upstream of the single-port memory and drives its valid/ready request port.
- Accepts one burst command (direction, start address, length) and turns it into a run of single-word memory transactions at consecutive addresses.
- Write data comes in on a valid/ready stream. Read data leaves on a valid-only stream.
- Replaces hand-sequenced bench/CPU accesses with a reusable hardware sequencer.

Parameters:
- WIDTH, 8, data word width (matches memory WIDTH)
- DEPTH, 32, memory depth in words
- ADDR_WIDTH, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  clock; all logic on rising edge
- res  in  1  reset, synchronous, active-low (res=0 at a rising clk edge resets)
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_wr  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  ADDR_WIDTH+1  word count, 0..DEPTH
- wd_valid  in  1  write-data word available
- wd_ready  out  1  write-data word consumed this cycle
- wd_data  in  WIDTH  write-data word
- rd_valid  out  1  one-cycle pulse per read word
- rd_data  out  WIDTH  read word, valid while rd_valid=1
- done  out  1  one-cycle pulse when the burst completes
- busy  out  1  high in any state other than IDLE
- m_valid  out  1  memory request valid
- m_wr_rd  out  1  memory direction, 1=write
- m_addr  out  ADDR_WIDTH  memory address
- m_wdata  out  WIDTH  memory write data
- m_rdata  in  WIDTH  memory read data
- m_ready  in  1  memory accept; for reads, m_rdata is valid in the same cycle

Behaviour:
- Reset values: cmd_ready=1, and every other output is 0. FSM goes to IDLE. Counters are cleared.
- Reset mid-burst: the burst is abandoned and m_valid drops on the next edge. No done pulse is generated. Memory contents already written are not restored.
- All outputs are registered, except cmd_ready and wd_ready, which are decoded from state.

FSM states:
- IDLE
  - cmd_ready=1.
  - When cmd_valid=1, latch cmd_wr, cmd_addr and cmd_len.
  - If cmd_len=0, go to DONE.
  - Otherwise go to WGET if cmd_wr=1, or RREQ if cmd_wr=0.
- WGET
  - wd_ready=1.
  - When wd_valid=1, load wd_data into m_wdata, drive m_wr_rd=1, m_addr=current address, m_valid=1, and go to WREQ.
- WREQ
  - Hold m_valid, m_addr, m_wdata and m_wr_rd stable until m_ready=1 is sampled.
  - On acceptance: decrement the remaining count and advance the address.
  - If the remaining count was 1: drop m_valid and go to DONE. Otherwise drop m_valid and go to WGET.
- RREQ
  - Drive m_valid=1, m_wr_rd=0, m_addr=current address. Hold until m_ready=1.
  - On acceptance: register m_rdata into rd_data and set rd_valid=1 for the next cycle.
  - Decrement the count and advance the address. Go to DONE on the last word, otherwise stay in RREQ.
  - m_valid deasserts for at least one cycle between words.
- DONE
  - done=1 for one cycle, then return to IDLE.

Timing and arithmetic:
- Each write word costs at least 2 cycles plus memory wait. Each read word costs at least 2 cycles.
- The address increments modulo DEPTH: start 30, length 4 gives addresses 30, 31, 0, 1.
- cmd_len > DEPTH is clamped to DEPTH.
- A command presented while busy is not accepted (cmd_ready=0). It must be held by the source.
- wd_valid outside WGET is ignored and no data is consumed.
- rd_valid appears exactly once per accepted read, one cycle after the m_ready cycle.
- The memory-side handshake follows the memory's rule: a transfer occurs on a rising edge where m_valid=1 and m_ready=1.

Decomposition:
- Shared package mem_pkg holds:
  - constants WIDTH and DEPTH, and the ADDR_WIDTH derivation;
  - the FSM state encoding (IDLE, WGET, WREQ, RREQ, DONE, 3 bits);
  - the direction constants MEM_WR=1 and MEM_RD=0.
- One natural sub-module, mem_addr_gen:
  - holds the start-address load, modulo-DEPTH increment and remaining-count register;
  - outputs last_word.
- Everything else sits in mem_burst_ctrl.

Test Plan:
- Single write then read: write command at addr 15, len 1, wd_data=0xA5; then read command at 15, len 1. Expect one m_valid write to addr 15 with data 0xA5, one done pulse per command, and rd_data=0xA5 with one rd_valid pulse.
- Five-word burst: write at addr 20, len 5, data 0x11..0x15; then read back. Expect m_addr sequence 20..24 and rd_data sequence 0x11..0x15.
- Wrap-around: write at 30, len 4, data 1..4. Expect m_addr 30, 31, 0, 1. A read at 0, len 2 returns 3, 4.
- Backpressure: the memory holds m_ready=0 for 3 cycles per request, and wd_valid has gaps. Expect m_addr and m_wdata stable throughout the stalls, no dropped or duplicated words, and exactly len wd_ready pulses.
- Edge lengths: len=0 gives done 2 cycles after acceptance with no m_valid. len=32 covers all locations. Issuing len=40 behaves identically to len=32.
- Reset mid-burst: assert res=0 during word 3 of an 8-word write. Expect all outputs to return to reset values on the next edge and no done pulse. A new command after res=1 is accepted.
